// File: rtl/instruction_fetch_unit_if.sv
// Signal bundle between the fetch unit and its PC, instruction memory, redirect
// source and IF/ID register. The fetch unit uses the master side.
interface instruction_fetch_unit_if #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32
);
   logic [ADDR_W-1:0]  pc_in;
   logic [ADDR_W-1:0]  pc_next;
   logic               pc_write;
   logic               imem_req_valid;
   logic [ADDR_W-1:0]  imem_req_addr;
   logic               imem_req_ready;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_addr;
   logic               stall;
   logic               inst_valid;
   logic [INSTR_W-1:0] inst_out;
   logic [ADDR_W-1:0]  inst_pc;

   modport master (
      input  pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_addr, stall,
      output pc_next, pc_write, imem_req_valid, imem_req_addr,
             inst_valid, inst_out, inst_pc
   );

   modport slave (
      output pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_addr, stall,
      input  pc_next, pc_write, imem_req_valid, imem_req_addr,
             inst_valid, inst_out, inst_pc
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// In-order instruction fetch with credit-limited requests, PC tag FIFO and an
// output queue. Define IFU_BYPASS_EN to forward responses past an empty queue.
module instruction_fetch_unit #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32,
   parameter int DEPTH   = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   instruction_fetch_unit_if.master  bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

   logic [INSTR_W-1:0] q_data_q [DEPTH];
   logic [ADDR_W-1:0]  q_pc_q   [DEPTH];
   logic [ADDR_W-1:0]  tag_q    [DEPTH];
   logic [PTR_W-1:0]   q_wr_q, q_rd_q, tag_wr_q, tag_rd_q;
   logic [CNT_W-1:0]   occ_q, inflight_q, discard_q;
   logic [CNT_W-1:0]   occ_d, inflight_d, discard_d;

   logic [CNT_W:0] used;
   logic           req_valid, accept, rsp_take, bypass, push, pop, q_empty;

   always_comb begin
      used      = (CNT_W + 1)'(inflight_q) + (CNT_W + 1)'(occ_q);
      q_empty   = (occ_q == '0);
      req_valid = !reset && !bus.redirect_valid && (used < DEPTH_C);
      accept    = req_valid && bus.imem_req_ready;
      // Responses landing on a redirect cycle belong to the old path.
      rsp_take  = !reset && bus.imem_rsp_valid && !bus.redirect_valid
                  && (discard_q == '0);
`ifdef IFU_BYPASS_EN
      bypass    = rsp_take && q_empty && !bus.stall;
`else
      bypass    = 1'b0;
`endif
      push      = rsp_take && !bypass;
      pop       = !q_empty && !bus.stall && !bus.redirect_valid;
   end

   always_comb begin
      inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(bus.imem_rsp_valid);
      if (bus.redirect_valid)
         discard_d = inflight_d;
      else
         discard_d = discard_q - CNT_W'(bus.imem_rsp_valid && (discard_q != '0));
      occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_comb begin
      bus.imem_req_valid = req_valid;
      bus.imem_req_addr  = bus.pc_in;
      bus.pc_write       = 1'b0;
      bus.pc_next        = bus.pc_in;
      if (!reset && bus.redirect_valid) begin
         bus.pc_write = 1'b1;
         bus.pc_next  = bus.redirect_addr;
      end else if (accept) begin
         bus.pc_write = 1'b1;
         bus.pc_next  = bus.pc_in + ADDR_W'(4);
      end
   end

   always_comb begin
`ifdef IFU_BYPASS_EN
      bus.inst_valid = !reset && (!q_empty || bypass);
      if (bypass) begin
         bus.inst_out = bus.imem_rsp_data;
         bus.inst_pc  = tag_q[tag_rd_q];
      end else begin
         bus.inst_out = q_empty ? '0 : q_data_q[q_rd_q];
         bus.inst_pc  = q_empty ? '0 : q_pc_q[q_rd_q];
      end
`else
      bus.inst_valid = !reset && !q_empty;
      bus.inst_out   = q_empty ? '0 : q_data_q[q_rd_q];
      bus.inst_pc    = q_empty ? '0 : q_pc_q[q_rd_q];
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_wr_q     <= '0;
         q_rd_q     <= '0;
         tag_wr_q   <= '0;
         tag_rd_q   <= '0;
         occ_q      <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         if (bus.redirect_valid) begin
            q_wr_q   <= '0;
            q_rd_q   <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            occ_q    <= '0;
         end else begin
            occ_q <= occ_d;
            if (accept) begin
               tag_q[tag_wr_q] <= bus.pc_in;
               tag_wr_q        <= tag_wr_q + 1'b1;
            end
            if (rsp_take)
               tag_rd_q <= tag_rd_q + 1'b1;
            if (push) begin
               q_data_q[q_wr_q] <= bus.imem_rsp_data;
               q_pc_q[q_wr_q]   <= tag_q[tag_rd_q];
               q_wr_q           <= q_wr_q + 1'b1;
            end
            if (pop)
               q_rd_q <= q_rd_q + 1'b1;
         end
      end
   end

   a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (reset)
      !(bus.imem_rsp_valid && (inflight_q == '0)));
endmodule
